// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the io_sdram word interface among video (port 0, fixed priority),
// CPU (port 1) and blitter (port 2, round-robin with port 1). Optional macro: SDRAM_ARB_STARVE_EN.
module sdram_arbiter #(
  parameter int NPORTS       = 3,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NPORTS-1:0]      req_i,
  input  logic [NPORTS-1:0]      req_we_i,
  input  logic [NPORTS*24-1:0]   req_addr_i,
  input  logic [NPORTS*32-1:0]   req_wdata_i,
  output logic [NPORTS-1:0]      ack_o,
  output logic [31:0]            rdata_o,
  output logic                   sdram_rd_o,
  output logic                   sdram_wr_o,
  output logic [23:0]            sdram_addr_o,
  output logic [31:0]            sdram_wdata_o,
  input  logic [31:0]            sdram_rdata_i,
  input  logic                   sdram_busy_i,
  input  logic                   sdram_rdata_valid_i,
  output logic [1:0]             grant_id_o
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_START, WR_WAIT} state_e;

  localparam logic [1:0] NONE = 2'd3;

  state_e                   state_q, state_d;
  logic [NPORTS-1:0]        ack_q, ack_d;
  logic [31:0]              rdata_q, rdata_d;
  logic                     rd_q, rd_d, wr_q, wr_d;
  logic [23:0]              addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [1:0]               grant_q, grant_d;
  logic [1:0]               rr_ptr_q, rr_ptr_d;

  logic [NPORTS-1:0][23:0]  p_addr;
  logic [NPORTS-1:0][31:0]  p_wdata;

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    assign p_addr[p]  = req_addr_i[24*p +: 24];
    assign p_wdata[p] = req_wdata_i[32*p +: 32];
  end

  logic       low_vld;
  logic [1:0] low_id;
  logic       starve_hit;
  logic       arb_go;
  logic [1:0] win_id;

  // Search the low ports starting at rr_ptr.
  always_comb begin
    low_vld = req_i[1] | req_i[2];
    if (rr_ptr_q == 2'd1) low_id = req_i[1] ? 2'd1 : 2'd2;
    else                  low_id = req_i[2] ? 2'd2 : 2'd1;
  end

  // No arbitration in an ack cycle: the acked port is still dropping its req.
  assign arb_go = (state_q == IDLE) && !sdram_busy_i && (|req_i) && (ack_q == '0);
  assign win_id = (req_i[0] && !(starve_hit && low_vld)) ? 2'd0 : low_id;

`ifdef SDRAM_ARB_STARVE_EN
  localparam int SCW = $clog2(STARVE_LIMIT + 1);

  logic [SCW-1:0] starve_cnt_q, starve_cnt_d;

  assign starve_hit = (starve_cnt_q == SCW'(STARVE_LIMIT));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (arb_go) begin
      if (win_id != 2'd0)        starve_cnt_d = '0;
      else if (low_vld && !starve_hit) starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) starve_cnt_q <= '0;
    else         starve_cnt_q <= starve_cnt_d;
  end
`else
  // Strict priority: the skip condition can never be met.
  assign starve_hit = (STARVE_LIMIT < 0);
`endif

  always_comb begin
    state_d  = state_q;
    ack_d    = '0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (arb_go) begin
          addr_d  = p_addr[win_id];
          wdata_d = p_wdata[win_id];
          grant_d = win_id;
          wr_d    = req_we_i[win_id];
          rd_d    = !req_we_i[win_id];
          state_d = req_we_i[win_id] ? WR_START : RD_WAIT;
          if (win_id != 2'd0) rr_ptr_d = (win_id == 2'd1) ? 2'd2 : 2'd1;
        end
      end
      RD_WAIT: begin
        if (sdram_rdata_valid_i) begin
          rdata_d        = sdram_rdata_i;
          ack_d[grant_q] = 1'b1;
          grant_d        = NONE;
          state_d        = IDLE;
        end
      end
      WR_START: begin
        if (sdram_busy_i) state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (!sdram_busy_i) begin
          ack_d[grant_q] = 1'b1;
          grant_d        = NONE;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      ack_q    <= '0;
      rdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      grant_q  <= NONE;
      rr_ptr_q <= 2'd1;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign ack_o         = ack_q;
  assign rdata_o       = rdata_q;
  assign sdram_rd_o    = rd_q;
  assign sdram_wr_o    = wr_q;
  assign sdram_addr_o  = addr_q;
  assign sdram_wdata_o = wdata_q;
  assign grant_id_o    = grant_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter; the bench plays the SDRAM controller by hand.
module tb_sdram_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, req_we;
  logic [71:0] req_addr;
  logic [95:0] req_wdata;
  logic [2:0]  ack;
  logic [31:0] rdata;
  logic        sdram_rd, sdram_wr;
  logic [23:0] sdram_addr;
  logic [31:0] sdram_wdata;
  logic [31:0] sdram_rdata;
  logic        sdram_busy, sdram_rdata_valid;
  logic [1:0]  grant_id;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdram_arbiter dut (
    .clk_i               (clk),
    .reset_i             (reset),
    .req_i               (req),
    .req_we_i            (req_we),
    .req_addr_i          (req_addr),
    .req_wdata_i         (req_wdata),
    .ack_o               (ack),
    .rdata_o             (rdata),
    .sdram_rd_o          (sdram_rd),
    .sdram_wr_o          (sdram_wr),
    .sdram_addr_o        (sdram_addr),
    .sdram_wdata_o       (sdram_wdata),
    .sdram_rdata_i       (sdram_rdata),
    .sdram_busy_i        (sdram_busy),
    .sdram_rdata_valid_i (sdram_rdata_valid),
    .grant_id_o          (grant_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_rd(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (sdram_rd === 1'b1) seen = 1'b1;
    end
  endtask

  // Serve one read for exp_port, then drop that port's req; rearm re-raises other reqs at grant.
  task automatic serve_read(input int exp_port, input logic [31:0] data, input logic [2:0] rearm);
    logic       seen;
    logic [2:0] onehot;
    onehot = 3'(1 << exp_port);
    wait_rd(seen);
    check("rd_strobe_seen", 32'(seen), 32'd1);
    check("grant_id", 32'(grant_id), 32'(exp_port));
    check("rd_addr", 32'(sdram_addr), 32'(req_addr[24*exp_port +: 24]));
    req = req | rearm;
    tick();
    check("rd_strobe_one_cycle", 32'(sdram_rd), 32'd0);
    sdram_rdata = data;
    sdram_rdata_valid = 1'b1;
    tick();
    sdram_rdata_valid = 1'b0;
    check("rd_ack", 32'(ack), 32'(onehot));
    check("rd_data", rdata, data);
    check("grant_none_after_ack", 32'(grant_id), 32'd3);
    req[exp_port] = 1'b0;
  endtask

  initial begin
    logic seen;
    int   strobes, n0;
    logic p1_seen;
    logic [1:0] g;

    reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    sdram_rdata = '0; sdram_busy = 1'b0; sdram_rdata_valid = 1'b0;
    tick(); tick();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rd", 32'(sdram_rd), 32'd0);
    check("rst_wr", 32'(sdram_wr), 32'd0);
    check("rst_addr", 32'(sdram_addr), 32'd0);
    check("rst_wdata", sdram_wdata, 32'd0);
    check("rst_grant", 32'(grant_id), 32'd3);
    reset = 1'b0;
    tick();

    // Single read on port 1
    req_addr = {24'h0, 24'h000123, 24'h0};
    req = 3'b010;
    tick();
    check("t1_rd", 32'(sdram_rd), 32'd1);
    check("t1_wr", 32'(sdram_wr), 32'd0);
    check("t1_addr", 32'(sdram_addr), 32'h000123);
    check("t1_grant", 32'(grant_id), 32'd1);
    tick();
    check("t1_rd_pulse", 32'(sdram_rd), 32'd0);
    check("t1_no_early_ack", 32'(ack), 32'd0);
    sdram_rdata = 32'hDEADBEEF; sdram_rdata_valid = 1'b1;
    tick();
    sdram_rdata_valid = 1'b0; req = 3'b000;
    check("t1_ack", 32'(ack), 32'b010);
    check("t1_rdata", rdata, 32'hDEADBEEF);
    check("t1_grant_none", 32'(grant_id), 32'd3);
    tick();
    check("t1_ack_pulse", 32'(ack), 32'd0);

    // Single write on port 2; port 1 we/addr must be ignored
    req_addr  = {24'h080000, 24'h111111, 24'h0};
    req_wdata = {32'hCAFEF00D, 32'h11111111, 32'h0};
    req_we = 3'b110; req = 3'b100;
    tick();
    check("t2_wr", 32'(sdram_wr), 32'd1);
    check("t2_rd", 32'(sdram_rd), 32'd0);
    check("t2_addr", 32'(sdram_addr), 32'h080000);
    check("t2_wdata", sdram_wdata, 32'hCAFEF00D);
    check("t2_grant", 32'(grant_id), 32'd2);
    req_addr = {24'h0ABCDE, 24'h111111, 24'h0};
    req_wdata = {32'h0BADBAD0, 32'h11111111, 32'h0};
    sdram_busy = 1'b1;
    strobes = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ack !== 3'b000 || sdram_wr !== 1'b0) strobes++;
    end
    check("t2_quiet_while_busy", 32'(strobes), 32'd0);
    sdram_busy = 1'b0;
    tick();
    check("t2_ack", 32'(ack), 32'b100);
    check("t2_grant_none", 32'(grant_id), 32'd3);
    check("t2_addr_held", 32'(sdram_addr), 32'h080000);
    check("t2_rdata_held", rdata, 32'hDEADBEEF);
    req = 3'b000; req_we = 3'b000;
    tick();
    check("t2_ack_pulse", 32'(ack), 32'd0);

    // Priority: 0,1,0,2,0,1 with each port dropping req after its ack
    req_addr = {24'h0C0002, 24'h0B0001, 24'h0A0000};
    req = 3'b111;
    serve_read(0, 32'h00000A00, 3'b000);
    serve_read(1, 32'h00000B01, 3'b001);
    serve_read(0, 32'h00000A02, 3'b010);
    serve_read(2, 32'h00000C03, 3'b001);
    serve_read(0, 32'h00000A04, 3'b100);
    serve_read(1, 32'h00000B05, 3'b001);
    req = 3'b000;
    tick(); tick();

    // Busy gating
    sdram_busy = 1'b1; req = 3'b001;
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sdram_rd !== 1'b0 || sdram_wr !== 1'b0) strobes++;
    end
    check("t4_no_strobe_busy", 32'(strobes), 32'd0);
    sdram_busy = 1'b0;
    tick();
    check("t4_rd_after_busy", 32'(sdram_rd), 32'd1);
    check("t4_grant", 32'(grant_id), 32'd0);
    tick();

    // Reset while in RD_WAIT, then a late rdata_valid
    reset = 1'b1;
    tick();
    reset = 1'b0; req = 3'b000;
    sdram_rdata = 32'h55555555; sdram_rdata_valid = 1'b1;
    tick();
    sdram_rdata_valid = 1'b0;
    check("t5_no_ack", 32'(ack), 32'd0);
    check("t5_grant", 32'(grant_id), 32'd3);
    check("t5_rdata", rdata, 32'd0);
    check("t5_addr", 32'(sdram_addr), 32'd0);
    check("t5_rd", 32'(sdram_rd), 32'd0);
    tick();
    check("t5_no_ack_late", 32'(ack), 32'd0);
    // rr_ptr back at port 1 after reset
    req_addr = {24'h000456, 24'h000123, 24'h0};
    req = 3'b110;
    serve_read(1, 32'h12345678, 3'b000);
    serve_read(2, 32'h9ABCDEF0, 3'b000);
    req = 3'b000;
    tick(); tick();

    // Ports 0 and 1 held continuously
    req_addr = {24'h0, 24'h000777, 24'h000333};
    req = 3'b011;
    n0 = 0; p1_seen = 1'b0;
    for (int k = 0; k < 12 && !p1_seen; k++) begin
      wait_rd(seen);
      check("t6_strobe_seen", 32'(seen), 32'd1);
      g = grant_id;
      if (g == 2'd1) p1_seen = 1'b1;
      else n0++;
      tick();
      sdram_rdata = 32'(k); sdram_rdata_valid = 1'b1;
      tick();
      sdram_rdata_valid = 1'b0;
      check("t6_ack", 32'(ack), 32'(3'(1 << g)));
      if (p1_seen) req[1] = 1'b0;
    end
`ifdef SDRAM_ARB_STARVE_EN
    check("t6_port0_grants", 32'(n0), 32'd8);
    check("t6_port1_granted", 32'(p1_seen), 32'd1);
`else
    check("t6_port0_grants", 32'(n0), 32'd12);
    check("t6_port1_granted", 32'(p1_seen), 32'd0);
`endif
    req = 3'b000;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
